// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer: fetch/decode/execute/memory/write-back FSM that
// owns the instruction register, the sign-extended immediate and all datapath strobes.
module multicycle_ctrl #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  input  logic          alu_zero,
  output logic          mem_req,
  output logic          mem_we,
  output logic          addr_sel,
  output logic          ir_we,
  output logic          pc_we,
  output logic          pc_src,
  output logic [1:0]    alu_op,
  output logic          alu_b_sel,
  output logic          reg_we,
  output logic          wb_sel,
  output logic [3:0]    rd_addr,
  output logic [3:0]    rs_addr,
  output logic [3:0]    rt_addr,
  output logic [DW-1:0] imm_q,
  output logic          busy,
  output logic          halted,
  output logic          illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t        state_reg;
  logic [DW-1:0] ir_reg;
  logic [DW-1:0] imm_reg;
  logic          illegal_reg;
  logic          armed_reg;

  logic [3:0] op;
  logic       is_rtype, is_addi, is_lw, is_sw, is_beq, is_halt, is_ill;

  assign op       = ir_reg[15:12];
  assign is_rtype = (op[3:2] == 2'b00);
  assign is_addi  = (op == 4'h4);
  assign is_lw    = (op == 4'h5);
  assign is_sw    = (op == 4'h6);
  assign is_beq   = (op == 4'h7);
  assign is_halt  = (op == 4'hF);
  assign is_ill   = op[3] && !is_halt;

  // armed_reg blocks a start that coincides with the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      ir_reg      <= '0;
      imm_reg     <= '0;
      illegal_reg <= 1'b0;
      armed_reg   <= 1'b0;
    end else begin
      armed_reg <= 1'b1;
      case (state_reg)
        S_IDLE: begin
          if (start && armed_reg) state_reg <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) begin
            ir_reg    <= mem_rdata;
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          imm_reg <= {{(DW-4){ir_reg[3]}}, ir_reg[3:0]};
          if (is_ill) illegal_reg <= 1'b1;
          state_reg <= is_halt ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          if (is_rtype || is_addi)  state_reg <= S_WB;
          else if (is_lw || is_sw)  state_reg <= S_MEM;
          else                      state_reg <= S_FETCH;
        end
        S_MEM: begin
          if (mem_ready) state_reg <= is_lw ? S_WB : S_FETCH;
        end
        S_WB: begin
          state_reg <= S_FETCH;
        end
        S_HALT: begin
          if (start) state_reg <= S_FETCH;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // ALU selects follow the opcode through EXEC, MEM and WB so the result stays valid.
  logic [1:0] op_alu;
  logic       op_b_sel;

  always_comb begin
    op_alu   = 2'b00;
    op_b_sel = 1'b0;
    if (is_rtype) begin
      op_alu = op[1:0];
    end else if (is_addi || is_lw || is_sw) begin
      op_b_sel = 1'b1;
    end else if (is_beq) begin
      op_alu = 2'b01;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    alu_op    = 2'b00;
    alu_b_sel = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        pc_we   = mem_ready;
      end
      S_EXEC: begin
        alu_op    = op_alu;
        alu_b_sel = op_b_sel;
        if (is_beq) begin
          pc_src = 1'b1;
          pc_we  = alu_zero;
        end
      end
      S_MEM: begin
        alu_op    = op_alu;
        alu_b_sel = op_b_sel;
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        mem_we    = is_sw;
      end
      S_WB: begin
        alu_op    = op_alu;
        alu_b_sel = op_b_sel;
        reg_we    = 1'b1;
        wb_sel    = is_lw;
      end
      default: ;
    endcase
  end

  // BEQ compares rd with rs, so rd is routed onto the rt read port during EXEC.
  assign rd_addr = ir_reg[11:8];
  assign rs_addr = ir_reg[7:4];
  assign rt_addr = (state_reg == S_EXEC && is_beq) ? ir_reg[11:8] : ir_reg[3:0];
  assign imm_q   = imm_reg;
  assign busy    = (state_reg != S_IDLE) && (state_reg != S_HALT);
  assign halted  = (state_reg == S_HALT);
  assign illegal = illegal_reg;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control sequencer for the 16-bit datapath. It fetches an instruction over a ready-handshaked memory port and decodes it. It captures the sign-extended 4-bit immediate, then steps the register file, ALU, memory and PC through execute, memory and write-back states. It sits between instruction/data memory and the datapath muxes, and is the only block that asserts datapath write enables.

## Interface
Parameters:
- DW, 16, datapath and instruction width (fixed at 16; immediate extends to DW)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; leaves IDLE or HALT
- mem_rdata  in  16  memory read data (instruction or load data)
- mem_ready  in  1  memory completes current request this cycle
- alu_zero  in  1  ALU result == 0
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- addr_sel  out  1  0 = PC, 1 = ALU result as memory address
- ir_we  out  1  instruction register load
- pc_we  out  1  PC load
- pc_src  out  1  0 = PC+1, 1 = PC + imm_q (branch)
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR
- alu_b_sel  out  1  0 = rt register, 1 = imm_q
- reg_we  out  1  register-file write
- wb_sel  out  1  0 = ALU, 1 = memory data
- rd_addr / rs_addr / rt_addr  out  4 each  IR[11:8] / IR[7:4] / IR[3:0]
- imm_q  out  16  registered sign extension of IR[3:0]
- busy  out  1  state not IDLE/HALT
- halted  out  1  state == HALT
- illegal  out  1  sticky; an undefined opcode was decoded

## Operation
- Instruction format: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt/imm4.
- Opcodes:
  - 0–3 ADD/SUB/AND/OR: rd = rs op rt.
  - 4 ADDI: rd = rs + sext(imm4).
  - 5 LW: rd = mem[rs + sext].
  - 6 SW: mem[rs + sext] = rd.
  - 7 BEQ: if rd == rs, PC = PC + sext.
  - F HALT.
  - 8–E are illegal: they set `illegal` and execute as NOP.
- IR holds the instruction internally. Decode uses IR, never mem_rdata.
- States:
  - IDLE → FETCH on start.
  - FETCH: mem_req=1, addr_sel=0. The FSM waits while !mem_ready. On mem_ready it pulses ir_we and pc_we (pc_src=0), then → DECODE.
  - DECODE: loads imm_q = {{12{IR[3]}}, IR[3:0]}. HALT → HALT; otherwise → EXEC.
  - EXEC:
    - R-type and ADDI: alu_op per opcode, alu_b_sel=1 for ADDI, then → WB.
    - LW/SW: ADD with alu_b_sel=1, then → MEM.
    - BEQ: SUB with alu_b_sel=0. If alu_zero, pulse pc_we with pc_src=1. Then → FETCH.
    - Illegal: → FETCH.
  - MEM: mem_req=1, addr_sel=1, mem_we=1 for SW. The FSM holds until mem_ready. Then LW → WB and SW → FETCH.
  - WB: pulse reg_we, with wb_sel=1 for LW. Then → FETCH.
  - HALT: halted=1. start → FETCH, and the PC is not reset.
- In every state, ALU and mux selects stay stable for the whole state, including mem_ready stall cycles.
- BEQ compares rd and rs. In EXEC, rt_addr is therefore driven with IR[11:8] so the ALU B port reads rd.

## Timing
- Reset (async assert, sync release):
  - State = IDLE.
  - IR = 0 and imm_q = 0.
  - illegal = 0.
  - All strobes and selects = 0, busy = 0, halted = 0.
- All strobes are Moore/Mealy-on-state and combinational from the registered state. The only Mealy inputs are ir_we/pc_we in FETCH (gated by mem_ready) and pc_we in EXEC (gated by alu_zero).
- Latency with zero-wait memory (mem_ready high on first request cycle):
  - R-type/ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - Each wait cycle adds 1 cycle.
- mem_req never drops before mem_ready, and mem_we is constant during the request.
- start while busy is ignored. start in the same cycle as rst_n deassertion is ignored.
- Reset mid-request drops mem_req immediately; a pending memory transaction is abandoned.
- illegal clears only on reset.

## Test plan
- Reset: hold rst_n=0 mid-FETCH. All outputs drop to 0 asynchronously, without a clock edge. After release, state is IDLE and busy=0.
- ADDI r1,r2,-8 (0x4128), zero-wait:
  - imm_q = 0xFFF8 in EXEC, with alu_b_sel=1 and alu_op=00.
  - reg_we at cycle 4, rd_addr=1.
  - Repeat with imm 0x7: imm_q = 0x0007.
- LW with mem_ready delayed 3 cycles in both FETCH and MEM:
  - mem_req held and addr_sel stable throughout.
  - reg_we with wb_sel=1 at cycle 11.
- SW (0x6345):
  - MEM has mem_we=1, addr_sel=1, imm_q=0x0005.
  - No reg_we, and control returns to FETCH.
- BEQ imm 0xF:
  - alu_zero=1: pc_we with pc_src=1 in EXEC, imm_q=0xFFFF.
  - alu_zero=0: no pc_we in EXEC.
- Opcode 0x9: illegal=1 and stays set, with no reg_we/mem_req outside FETCH. Then HALT (0xF000) sets halted=1, and start resumes at FETCH.
